// File: rtl/logIP_pkg.sv
// rtl/logIP_pkg.sv - shared SUMP/OLS opcode definitions and command decode
package logIP_pkg;

  typedef logic [7:0] opcode_t;

  localparam opcode_t CMD_S_SOFT_RESET    = 8'h00;
  localparam opcode_t CMD_S_RUN           = 8'h01;
  localparam opcode_t CMD_S_ID            = 8'h02;
  localparam opcode_t CMD_S_META          = 8'h04;
  localparam opcode_t CMD_S_FINISH_NOW    = 8'h05;
  localparam opcode_t CMD_S_QUERY_INPUT   = 8'h06;
  localparam opcode_t CMD_S_ARM_ADVANCED  = 8'h0F;
  localparam opcode_t CMD_S_XON           = 8'h11;
  localparam opcode_t CMD_S_XOFF          = 8'h13;
  localparam opcode_t CMD_L_SET_DIVIDER   = 8'h80;
  localparam opcode_t CMD_L_SET_READ_DLY  = 8'h81;
  localparam opcode_t CMD_L_SET_FLAGS     = 8'h82;
  localparam opcode_t CMD_L_SET_ADV_SEL   = 8'h9E;
  localparam opcode_t CMD_L_SET_ADV_DATA  = 8'h9F;

  typedef enum logic {PS_IDLE, PS_ARG} parser_state_t;

  localparam int CMD_LONG_ARG_BYTES = 4;

  // Trigger stage commands are 0b1100_ssxx with xx = mask/value/config; xx=11 is unused.
  function automatic logic is_valid_opcode(input logic [7:0] op);
    if (op[7:4] == 4'hC) begin
      return op[1:0] != 2'b11;
    end
    case (op)
      CMD_S_SOFT_RESET, CMD_S_RUN, CMD_S_ID, CMD_S_META, CMD_S_FINISH_NOW,
      CMD_S_QUERY_INPUT, CMD_S_ARM_ADVANCED, CMD_S_XON, CMD_S_XOFF,
      CMD_L_SET_DIVIDER, CMD_L_SET_READ_DLY, CMD_L_SET_FLAGS,
      CMD_L_SET_ADV_SEL, CMD_L_SET_ADV_DATA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - assembles short/long SUMP commands from the UART byte stream
module cmd_parser
  import logIP_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_stb_i,
  output opcode_t     cmd_o,
  output logic [31:0] data_o,
  output logic        exe_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [1:0] LAST_IDX = 2'(CMD_LONG_ARG_BYTES - 1);

  parser_state_t state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    op_q, op_d;
  logic [23:0]   arg_q, arg_d;
  opcode_t       cmd_q, cmd_d;
  logic [31:0]   data_q, data_d;
  logic          exe_q, exe_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    arg_d   = arg_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    exe_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      PS_IDLE: begin
        if (rx_stb_i) begin
          if (!rx_data_i[7]) begin
            if (is_valid_opcode(rx_data_i)) begin
              cmd_d  = rx_data_i;
              data_d = '0;
              exe_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            op_d    = rx_data_i;
            idx_d   = '0;
            tmo_d   = '0;
            state_d = PS_ARG;
          end
        end
      end
      PS_ARG: begin
        if (rx_stb_i) begin
          tmo_d = '0;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    arg_d[7:0]   = rx_data_i;
            2'd1:    arg_d[15:8]  = rx_data_i;
            2'd2:    arg_d[23:16] = rx_data_i;
            default: arg_d        = arg_q;
          endcase
          // Decode only once all argument bytes are in, so unknown long opcodes stay aligned.
          if (idx_q == LAST_IDX) begin
            state_d = PS_IDLE;
            if (is_valid_opcode(op_q)) begin
              cmd_d  = op_q;
              data_d = {rx_data_i, arg_q};
              exe_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (tmo_q == TMO_MAX) begin
          state_d = PS_IDLE;
          idx_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PS_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      cmd_q   <= CMD_S_SOFT_RESET;
      data_q  <= '0;
      exe_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      exe_q   <= exe_d;
      err_q   <= err_d;
    end
  end

  assign cmd_o  = cmd_q;
  assign data_o = data_q;
  assign exe_o  = exe_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == PS_ARG);

endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - table-driven and directed checks of cmd_parser
module tb_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_stb = 1'b0;
  logic [7:0]  cmd;
  logic [31:0] data;
  logic        exe, err, busy;

  int n_vec = 0;
  int n_bad = 0;

  cmd_parser #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .rx_data_i(rx_data),
    .rx_stb_i (rx_stb),
    .cmd_o    (cmd),
    .data_o   (data),
    .exe_o    (exe),
    .err_o    (err),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stb;
    logic [7:0]  din;
    logic        e_exe;
    logic        e_err;
    logic        e_busy;
    logic [7:0]  e_cmd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [7:0] d, input logic ee,
                     input logic er, input logic eb, input logic [7:0] ec, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.stb = s; v.din = d; v.e_exe = ee; v.e_err = er;
    v.e_busy = eb; v.e_cmd = ec; v.e_data = ed;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the DUT clock them in, then sample just after the edge.
  task automatic step(input logic r, input logic s, input logic [7:0] d);
    rst = r; rx_stb = s; rx_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; rx_stb = 1'b0;
  endtask

  task automatic check(input string name, input logic ee, input logic er, input logic eb,
                       input logic [7:0] ec, input logic [31:0] ed);
    n_vec++;
    if (exe !== ee || err !== er || busy !== eb || cmd !== ec || data !== ed) begin
      n_bad++;
      $display("FAIL %s: got exe=%b err=%b busy=%b cmd=%02h data=%08h, want exe=%b err=%b busy=%b cmd=%02h data=%08h",
               name, exe, err, busy, cmd, data, ee, er, eb, ec, ed);
    end
  endtask

  initial begin
    // rst stb din   exe err busy cmd    data
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0);
    add(0, 1, 8'h02, 1, 0, 0, 8'h02, 32'h0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h02, 32'h0);
    add(0, 1, 8'h80, 0, 0, 1, 8'h02, 32'h0);
    add(0, 1, 8'h63, 0, 0, 1, 8'h02, 32'h0);
    add(0, 1, 8'h00, 0, 0, 1, 8'h02, 32'h0);
    add(0, 1, 8'h00, 0, 0, 1, 8'h02, 32'h0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h80, 32'h0000_0063);
    add(0, 1, 8'hC5, 0, 0, 1, 8'h80, 32'h0000_0063);
    add(0, 1, 8'hFF, 0, 0, 1, 8'h80, 32'h0000_0063);
    add(0, 1, 8'hFF, 0, 0, 1, 8'h80, 32'h0000_0063);
    add(0, 1, 8'hFF, 0, 0, 1, 8'h80, 32'h0000_0063);
    add(0, 1, 8'hFF, 1, 0, 0, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'hC3, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h12, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h34, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h56, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h78, 0, 1, 0, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h07, 0, 1, 0, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h83, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h01, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h02, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h03, 0, 0, 1, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h04, 0, 1, 0, 8'hC5, 32'hFFFF_FFFF);
    add(0, 1, 8'h13, 1, 0, 0, 8'h13, 32'h0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h13, 32'h0);
    // stuck 0x82 with two args, then five 0x00 realign the stream
    add(0, 1, 8'h82, 0, 0, 1, 8'h13, 32'h0);
    add(0, 1, 8'hAA, 0, 0, 1, 8'h13, 32'h0);
    add(0, 1, 8'hBB, 0, 0, 1, 8'h13, 32'h0);
    add(0, 1, 8'h00, 0, 0, 1, 8'h13, 32'h0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h82, 32'h0000_BBAA);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 32'h0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 32'h0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 32'h0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0);
    add(0, 1, 8'h9F, 0, 0, 1, 8'h00, 32'h0);
    add(0, 1, 8'h11, 0, 0, 1, 8'h00, 32'h0);
    add(0, 1, 8'h22, 0, 0, 1, 8'h00, 32'h0);
    add(0, 1, 8'h33, 0, 0, 1, 8'h00, 32'h0);
    add(0, 1, 8'h44, 1, 0, 0, 8'h9F, 32'h4433_2211);
    add(0, 1, 8'hC2, 0, 0, 1, 8'h9F, 32'h4433_2211);
    add(0, 1, 8'h01, 0, 0, 1, 8'h9F, 32'h4433_2211);
    add(0, 1, 8'h00, 0, 0, 1, 8'h9F, 32'h4433_2211);
    add(0, 1, 8'h00, 0, 0, 1, 8'h9F, 32'h4433_2211);
    add(0, 1, 8'h80, 1, 0, 0, 8'hC2, 32'h8000_0001);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].stb, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].e_exe, vecs[i].e_err, vecs[i].e_busy,
            vecs[i].e_cmd, vecs[i].e_data);
    end

    // Inter-byte timeout: 8 quiet cycles are tolerated, the next one fires err_o.
    step(0, 1, 8'h81);
    step(0, 1, 8'h11);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 8'h00);
      check($sformatf("tmo_wait%0d", i), 0, 0, 1, 8'hC2, 32'h8000_0001);
    end
    step(0, 0, 8'h00);
    check("tmo_fire", 0, 1, 0, 8'hC2, 32'h8000_0001);
    step(0, 0, 8'h00);
    check("tmo_pulse_end", 0, 0, 0, 8'hC2, 32'h8000_0001);
    step(0, 1, 8'h02);
    check("tmo_then_short", 1, 0, 0, 8'h02, 32'h0);

    // A strobe in the deciding cycle wins over the timeout.
    step(0, 1, 8'h81);
    step(0, 1, 8'h11);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00);
    step(0, 1, 8'h22);
    check("tmo_race_accept", 0, 0, 1, 8'h02, 32'h0);
    step(0, 1, 8'h33);
    step(0, 1, 8'h44);
    check("tmo_race_exec", 1, 0, 0, 8'h81, 32'h4433_2211);

    // Reset mid-command discards silently.
    step(0, 1, 8'h80);
    step(0, 1, 8'h55);
    step(0, 1, 8'h66);
    check("pre_reset_busy", 0, 0, 1, 8'h81, 32'h4433_2211);
    step(1, 1, 8'h77);
    check("mid_reset", 0, 0, 0, 8'h00, 32'h0);
    step(0, 0, 8'h00);
    check("post_reset_quiet", 0, 0, 0, 8'h00, 32'h0);
    step(0, 1, 8'h01);
    check("post_reset_run", 1, 0, 0, 8'h01, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
